// File: rtl/rx_buffer_assembler.sv
// Packs a uart_rx byte stream MSB-first into a DEPTH x WIDTH array and
// presents the finished array to the sorter. Partial arrays are dropped on a
// line error or when the gap between bytes exceeds TIMEOUT_CYCLES.
//
// Handshake: valid_out is high while a complete array sits on array_out; the
// array is taken on any rising edge where valid_out & ready_in. valid_out
// never falls without that handshake (except on reset), and array_out does
// not change while valid_out is high.
module rx_buffer_assembler #(
   parameter int WIDTH          = 32,
   parameter int DEPTH          = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       byte_in,
   input  logic             byte_valid,
   input  logic             rx_err,
   output logic [WIDTH-1:0] array_out [DEPTH-1:0],
   output logic             valid_out,
   input  logic             ready_in,
   output logic             overrun_err,
   output logic             timeout_err,
   output logic [1:0]       state_dbg
);

   localparam int BPW   = WIDTH / 8;
   localparam int N     = DEPTH * BPW;
   // A single-byte array still needs a one-bit counter to be legal.
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              ovr_q, ovr_d;
   logic              tout_q, tout_d;
   logic              wr_en;
   logic [CNT_W-1:0]  wr_idx;
   logic [WIDTH-1:0]  array_q [DEPTH];

   // Count value after storing the first byte of a new array.
   localparam logic [CNT_W-1:0] CNT_AFTER_FIRST = (N == 1) ? '0 : CNT_W'(1);

   // State, byte counter, gap timer and error pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tmo_q   <= '0;
         ovr_q   <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         ovr_q   <= ovr_d;
         tout_q  <= tout_d;
      end
   end

   // Next-state logic: byte acceptance, discard on error/timeout, handshake.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      ovr_d   = 1'b0;
      tout_d  = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = cnt_q;
      unique case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (rx_err) begin
               cnt_d = '0;
            end else if (byte_valid) begin
               wr_en   = 1'b1;
               wr_idx  = '0;
               cnt_d   = CNT_AFTER_FIRST;
               state_d = (N == 1) ? HOLD : COLLECT;
            end
         end
         COLLECT: begin
            if (rx_err) begin
               state_d = IDLE;
               cnt_d   = '0;
               tmo_d   = '0;
            end else if (byte_valid) begin
               // A byte on the final timer cycle wins over the timeout.
               wr_en = 1'b1;
               tmo_d = '0;
               if (cnt_q == CNT_W'(N - 1)) begin
                  state_d = HOLD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
               tmo_d   = '0;
               tout_d  = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         HOLD: begin
            // rx_err is ignored here: the held array is already complete.
            tmo_d = '0;
            if (ready_in) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (byte_valid) begin
                  wr_en   = 1'b1;
                  wr_idx  = '0;
                  cnt_d   = CNT_AFTER_FIRST;
                  state_d = (N == 1) ? HOLD : COLLECT;
               end
            end else if (byte_valid) begin
               ovr_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            tmo_d   = '0;
         end
      endcase
   end

   // Array storage: byte k lands in word k/BPW, MSB-first within the word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < DEPTH; w++) begin
            array_q[w] <= '0;
         end
      end else if (wr_en) begin
         for (int w = 0; w < DEPTH; w++) begin
            for (int b = 0; b < BPW; b++) begin
               if (wr_idx == CNT_W'(w * BPW + b)) begin
                  array_q[w][WIDTH-1-8*b -: 8] <= byte_in;
               end
            end
         end
      end
   end

   // Drive the array output from the storage registers.
   always_comb begin
      for (int w = 0; w < DEPTH; w++) begin
         array_out[w] = array_q[w];
      end
   end

   assign valid_out   = (state_q == HOLD);
   assign overrun_err = ovr_q;
   assign timeout_err = tout_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_rx_buffer_assembler.sv
// Directed bench for rx_buffer_assembler (WIDTH=32, DEPTH=8, TIMEOUT_CYCLES=64).
module tb_rx_buffer_assembler;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int TMO   = 64;

   localparam logic [31:0] S_IDLE    = 32'd0;
   localparam logic [31:0] S_COLLECT = 32'd1;
   localparam logic [31:0] S_HOLD    = 32'd2;

   logic             clk;
   logic             rst_n;
   logic [7:0]       byte_in;
   logic             byte_valid;
   logic             rx_err;
   logic [WIDTH-1:0] array_out [DEPTH-1:0];
   logic             valid_out;
   logic             ready_in;
   logic             overrun_err;
   logic             timeout_err;
   logic [1:0]       state_dbg;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Event counters sampled on the falling edge.
   int hs_cnt   = 0;
   int ovr_cnt  = 0;
   int tout_cnt = 0;
   logic [WIDTH-1:0] acc [DEPTH];
   int hs0, ovr0, tout0;

   rx_buffer_assembler #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .byte_in(byte_in),
      .byte_valid(byte_valid),
      .rx_err(rx_err),
      .array_out(array_out),
      .valid_out(valid_out),
      .ready_in(ready_in),
      .overrun_err(overrun_err),
      .timeout_err(timeout_err),
      .state_dbg(state_dbg)
   );

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: handshakes (with the accepted array) and error pulses.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_out && ready_in) begin
            hs_cnt++;
            for (int w = 0; w < DEPTH; w++) acc[w] = array_out[w];
         end
         if (overrun_err) ovr_cnt++;
         if (timeout_err) tout_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   // Sends n bytes start, start+1, ... with gap idle cycles between them.
   task automatic send_stream(input logic [7:0] start, input int n, input int gap);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         if (i > 0) idle(gap);
         b = start + i[7:0];
         send_byte(b);
      end
   endtask

   task automatic snap();
      hs0   = hs_cnt;
      ovr0  = ovr_cnt;
      tout0 = tout_cnt;
   endtask

   initial begin
      rst_n      = 1'b0;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      rx_err     = 1'b0;
      ready_in   = 1'b0;
      idle(3);

      // Reset values.
      check("rst_valid", {31'd0, valid_out}, 32'd0);
      check("rst_ovr", {31'd0, overrun_err}, 32'd0);
      check("rst_tout", {31'd0, timeout_err}, 32'd0);
      check("rst_state", {30'd0, state_dbg}, S_IDLE);
      check("rst_arr0", array_out[0], 32'h0);
      rst_n = 1'b1;
      idle(2);

      // 1: spaced stream 0x41..0x60, ready high.
      ready_in = 1'b1;
      snap();
      send_stream(8'h41, 31, 9);
      check("t1_not_valid_early", {31'd0, valid_out}, 32'd0);
      idle(9);
      send_byte(8'h60);
      check("t1_valid", {31'd0, valid_out}, 32'd1);
      check("t1_w0", array_out[0], 32'h41424344);
      check("t1_w7", array_out[7], 32'h5D5E5F60);
      idle(1);
      check("t1_valid_drop", {31'd0, valid_out}, 32'd0);
      check("t1_hs", hs_cnt - hs0, 32'd1);
      check("t1_acc7", acc[7], 32'h5D5E5F60);
      check("t1_errs", (ovr_cnt - ovr0) + (tout_cnt - tout0), 32'd0);

      // 2: hold with ready low, overrun byte, then accept.
      ready_in = 1'b0;
      snap();
      send_stream(8'h80, 32, 0);
      check("t2_state_hold", {30'd0, state_dbg}, S_HOLD);
      idle(10);
      send_byte(8'hAA);
      check("t2_ovr_pulse", {31'd0, overrun_err}, 32'd1);
      idle(1);
      check("t2_ovr_one_cycle", {31'd0, overrun_err}, 32'd0);
      idle(38);
      check("t2_still_valid", {31'd0, valid_out}, 32'd1);
      check("t2_w0_frozen", array_out[0], 32'h80818283);
      check("t2_w7_frozen", array_out[7], 32'h9C9D9E9F);
      ready_in = 1'b1;
      idle(1);
      check("t2_valid_drop", {31'd0, valid_out}, 32'd0);
      check("t2_hs", hs_cnt - hs0, 32'd1);
      check("t2_acc0", acc[0], 32'h80818283);
      check("t2_ovr_total", ovr_cnt - ovr0, 32'd1);
      send_stream(8'h20, 32, 0);
      check("t2_next_w0", array_out[0], 32'h20212223);
      check("t2_next_w7", array_out[7], 32'h3C3D3E3F);
      idle(1);

      // 3: timeout after 5 bytes, then an all-0xFF array.
      snap();
      send_stream(8'h10, 5, 0);
      idle(TMO - 1);
      check("t3_no_tout_early", {31'd0, timeout_err}, 32'd0);
      check("t3_state_collect", {30'd0, state_dbg}, S_COLLECT);
      idle(1);
      check("t3_tout_pulse", {31'd0, timeout_err}, 32'd1);
      check("t3_state_idle", {30'd0, state_dbg}, S_IDLE);
      idle(1);
      check("t3_tout_one_cycle", {31'd0, timeout_err}, 32'd0);
      for (int i = 0; i < 32; i++) send_byte(8'hFF);
      check("t3_valid", {31'd0, valid_out}, 32'd1);
      for (int w = 0; w < DEPTH; w++) check($sformatf("t3_w%0d", w), array_out[w], 32'hFFFFFFFF);
      idle(1);
      check("t3_tout_total", tout_cnt - tout0, 32'd1);

      // 4: 12 bytes, rx_err with a coincident byte, then 0x00..0x1F.
      snap();
      send_stream(8'hA0, 12, 0);
      rx_err     = 1'b1;
      byte_in    = 8'hEE;
      byte_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_err     = 1'b0;
      byte_valid = 1'b0;
      check("t4_state_idle", {30'd0, state_dbg}, S_IDLE);
      send_stream(8'h00, 32, 0);
      check("t4_w0", array_out[0], 32'h00010203);
      check("t4_w7", array_out[7], 32'h1C1D1E1F);
      idle(1);
      check("t4_no_tout", tout_cnt - tout0, 32'd0);

      // 5: handshake coincident with a new byte.
      ready_in = 1'b0;
      snap();
      send_stream(8'h60, 32, 0);
      ready_in   = 1'b1;
      byte_in    = 8'h55;
      byte_valid = 1'b1;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      check("t5_valid_drop", {31'd0, valid_out}, 32'd0);
      check("t5_state_collect", {30'd0, state_dbg}, S_COLLECT);
      idle(1);
      check("t5_no_ovr", ovr_cnt - ovr0, 32'd0);
      check("t5_hs", hs_cnt - hs0, 32'd1);
      send_stream(8'h56, 31, 0);
      check("t5_valid", {31'd0, valid_out}, 32'd1);
      check("t5_w0", array_out[0], 32'h55565758);
      check("t5_w7", array_out[7], 32'h71727374);
      idle(1);

      // 6: reset mid-collect and mid-hold, then a fresh stream.
      send_stream(8'h01, 20, 0);
      rst_n = 1'b0;
      #1;
      check("t6_rst_collect_state", {30'd0, state_dbg}, S_IDLE);
      idle(2);
      rst_n    = 1'b1;
      ready_in = 1'b0;
      idle(1);
      send_stream(8'h40, 32, 0);
      check("t6_hold_valid", {31'd0, valid_out}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_hold_valid", {31'd0, valid_out}, 32'd0);
      check("t6_rst_hold_arr0", array_out[0], 32'h0);
      check("t6_rst_hold_arr7", array_out[7], 32'h0);
      idle(2);
      rst_n    = 1'b1;
      ready_in = 1'b1;
      idle(1);
      send_stream(8'hC0, 32, 0);
      check("t6_fresh_w0", array_out[0], 32'hC0C1C2C3);
      check("t6_fresh_w7", array_out[7], 32'hDCDDDEDF);
      idle(2);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
